// File: rtl/video_src_switch_pkg.sv
// Shared types and helpers for the video source switch.
// Contents: switch FSM state enum, sync polarity constant, frame counter
// width, and a helper that returns the low bit of a slice in a packed bus.
package video_src_switch_pkg;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        WAIT_VS = 2'd1,
        BLANK   = 2'd2
    } state_e;

    // Syncs are active-low; this is the idle level.
    localparam logic SYNC_INACTIVE = 1'b1;

    localparam int unsigned FRAME_CNT_W = 4;

    // Low bit index of element idx in a bus packed as width-bit fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/video_src_switch_vs_edge_det.sv
// Registered VSYNC falling-edge detector with synchronous reload.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   vs_in      - VSYNC currently being watched (active-low)
//   reload     - watched source changes this cycle
//   reload_vs  - VSYNC of the source that will be watched next cycle
//   fall_c     - combinational falling-edge flag (previous high, now low)
module video_src_switch_vs_edge_det
    import video_src_switch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic vs_in,
    input  logic reload,
    input  logic reload_vs,
    output logic fall_c
);

    logic vs_prev_q;
    logic vs_prev_d;

    // Reloading from the new source avoids a false edge when switching.
    always_comb begin
        vs_prev_d = vs_in;
        if (reload) begin
            vs_prev_d = reload_vs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= SYNC_INACTIVE;
        end else begin
            vs_prev_q <= vs_prev_d;
        end
    end

    assign fall_c = vs_prev_q & ~vs_in;

endmodule

// File: rtl/video_src_switch.sv
// N-input video source selector that switches only on frame boundaries and
// blanks RGB/DE for BLANK_FRAMES frames of the new source after each switch.
// Ports:
//   PCLK_in, reset           - pixel clock, asynchronous active-high reset
//   sel_req                  - requested source index (level)
//   R_in/G_in/B_in           - packed per-source colour, source k at [k*CW +: CW]
//   HSYNC_in/VSYNC_in/DE_in  - per-source syncs (active-low) and data enable
//   R_out..DATA_enable       - registered selected video, 1 cycle latency
//   sel_active               - source currently routed to the outputs
//   switching                - high while waiting for the frame edge or blanking
//   sel_invalid              - one-cycle pulse on a newly presented invalid sel_req
module video_src_switch
    import video_src_switch_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned CW           = 8,
    parameter int unsigned SELW         = ($clog2(NUM_SRC) < 1) ? 1 : $clog2(NUM_SRC),
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned TIMEOUT      = 1048576
) (
    input  logic                  PCLK_in,
    input  logic                  reset,
    input  logic [SELW-1:0]       sel_req,
    input  logic [NUM_SRC*CW-1:0] R_in,
    input  logic [NUM_SRC*CW-1:0] G_in,
    input  logic [NUM_SRC*CW-1:0] B_in,
    input  logic [NUM_SRC-1:0]    HSYNC_in,
    input  logic [NUM_SRC-1:0]    VSYNC_in,
    input  logic [NUM_SRC-1:0]    DE_in,
    output logic [CW-1:0]         R_out,
    output logic [CW-1:0]         G_out,
    output logic [CW-1:0]         B_out,
    output logic                  HSYNC_out,
    output logic                  VSYNC_out,
    output logic                  DATA_enable,
    output logic [SELW-1:0]       sel_active,
    output logic                  switching,
    output logic                  sel_invalid
);

    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]        TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]        TO_MAX     = '1;
    localparam logic [SELW:0]          NUM_SRC_W  = (SELW + 1)'(NUM_SRC);
    localparam logic [FRAME_CNT_W-1:0] BLANK_LAST = FRAME_CNT_W'(BLANK_FRAMES);

    state_e                 state_q, state_d;
    logic [SELW-1:0]        target_q, target_d;
    logic [SELW-1:0]        sel_active_q, sel_active_d;
    logic [SELW-1:0]        sel_req_prev_q, sel_req_prev_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [CW-1:0]          r_q, r_d, g_q, g_d, b_q, b_d;
    logic                   hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic                   switching_q, switching_d;
    logic                   sel_invalid_q, sel_invalid_d;

    logic                   req_valid_c;
    logic                   vs_fall_c;
    int unsigned            lo_c;

    assign req_valid_c = ({1'b0, sel_req} < NUM_SRC_W);
    assign lo_c        = slice_lo(32'(sel_active_q), CW);

    // Falling edge of the currently routed source's VSYNC.
    video_src_switch_vs_edge_det u_vs_edge (
        .clk       (PCLK_in),
        .rst       (reset),
        .vs_in     (VSYNC_in[sel_active_q]),
        .reload    (sel_active_d != sel_active_q),
        .reload_vs (VSYNC_in[sel_active_d]),
        .fall_c    (vs_fall_c)
    );

    // Switch FSM next state and registered output datapath.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        sel_active_d   = sel_active_q;
        frame_cnt_d    = frame_cnt_q;
        to_cnt_d       = to_cnt_q;
        sel_req_prev_d = sel_req;
        sel_invalid_d  = (sel_req != sel_req_prev_q) && !req_valid_c;

        case (state_q)
            ACTIVE: begin
                if (req_valid_c && (sel_req != sel_active_q)) begin
                    target_d = sel_req;
                    to_cnt_d = '0;
                    state_d  = WAIT_VS;
                end
            end
            WAIT_VS: begin
                // Retarget keeps the timeout running from the original request.
                if (req_valid_c && (sel_req != target_q)) begin
                    target_d = sel_req;
                end
                if (vs_fall_c || (to_cnt_q == TO_LAST)) begin
                    sel_active_d = target_d;
                    frame_cnt_d  = '0;
                    state_d      = BLANK;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            BLANK: begin
                if (req_valid_c && (sel_req != sel_active_q)) begin
                    target_d = sel_req;
                    to_cnt_d = '0;
                    state_d  = WAIT_VS;
                end else if (vs_fall_c) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    if (frame_cnt_d == BLANK_LAST) begin
                        state_d = ACTIVE;
                    end
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase

        // Syncs always track the routed source; pixels only when unblanked.
        hs_d = HSYNC_in[sel_active_q];
        vs_d = VSYNC_in[sel_active_q];
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        de_d = 1'b0;
        if (state_q == ACTIVE) begin
            r_d  = R_in[lo_c +: CW];
            g_d  = G_in[lo_c +: CW];
            b_d  = B_in[lo_c +: CW];
            de_d = DE_in[sel_active_q];
        end
        switching_d = (state_d != ACTIVE);
    end

    always_ff @(posedge PCLK_in or posedge reset) begin
        if (reset) begin
            state_q        <= BLANK;
            target_q       <= '0;
            sel_active_q   <= '0;
            sel_req_prev_q <= '0;
            frame_cnt_q    <= '0;
            to_cnt_q       <= '0;
            r_q            <= '0;
            g_q            <= '0;
            b_q            <= '0;
            hs_q           <= SYNC_INACTIVE;
            vs_q           <= SYNC_INACTIVE;
            de_q           <= 1'b0;
            switching_q    <= 1'b1;
            sel_invalid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            sel_active_q   <= sel_active_d;
            sel_req_prev_q <= sel_req_prev_d;
            frame_cnt_q    <= frame_cnt_d;
            to_cnt_q       <= to_cnt_d;
            r_q            <= r_d;
            g_q            <= g_d;
            b_q            <= b_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            de_q           <= de_d;
            switching_q    <= switching_d;
            sel_invalid_q  <= sel_invalid_d;
        end
    end

    assign R_out       = r_q;
    assign G_out       = g_q;
    assign B_out       = b_q;
    assign HSYNC_out   = hs_q;
    assign VSYNC_out   = vs_q;
    assign DATA_enable = de_q;
    assign sel_active  = sel_active_q;
    assign switching   = switching_q;
    assign sel_invalid = sel_invalid_q;

endmodule

// File: tb/tb_video_src_switch.sv
// Self-checking bench for video_src_switch (3 sources, TIMEOUT=1000).
module tb_video_src_switch;

    localparam int NS = 3;
    localparam int CW = 8;
    localparam int SW = 2;
    localparam int BF = 2;
    localparam int TO = 1000;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_BLANK = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [SW-1:0]     sel_req;
    logic [NS*CW-1:0]  r_in, g_in, b_in;
    logic [NS-1:0]     hs_in, vs_in, de_in;
    logic [CW-1:0]     R_out, G_out, B_out;
    logic              HSYNC_out, VSYNC_out, DATA_enable;
    logic [SW-1:0]     sel_active;
    logic              switching, sel_invalid;

    video_src_switch #(
        .NUM_SRC(NS), .CW(CW), .SELW(SW), .BLANK_FRAMES(BF), .TIMEOUT(TO)
    ) dut (
        .PCLK_in(clk), .reset(rst), .sel_req(sel_req),
        .R_in(r_in), .G_in(g_in), .B_in(b_in),
        .HSYNC_in(hs_in), .VSYNC_in(vs_in), .DE_in(de_in),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DATA_enable(DATA_enable),
        .sel_active(sel_active), .switching(switching), .sel_invalid(sel_invalid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Source timing generators: frame of fl[k] pixels, VSYNC low for 5 pixels.
    int pos [NS];
    int fl  [NS] = '{97, 131, 113};
    bit hold[NS];

    // Reference model: per-source last VSYNC, absolute timeout deadline,
    // frames-left countdown.
    int      m_mode, m_cur, m_tgt, m_left, m_prev_req;
    longint  edge_n = 0;
    longint  deadline;
    bit      vs_last[NS];
    logic [CW-1:0] e_r, e_g, e_b;
    logic          e_hs, e_vs, e_de, e_sw, e_inv;
    logic [SW-1:0] e_sel;

    task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_v("R_out",       32'(R_out),       32'(e_r));
        check_v("G_out",       32'(G_out),       32'(e_g));
        check_v("B_out",       32'(B_out),       32'(e_b));
        check_v("HSYNC_out",   32'(HSYNC_out),   32'(e_hs));
        check_v("VSYNC_out",   32'(VSYNC_out),   32'(e_vs));
        check_v("DATA_enable", 32'(DATA_enable), 32'(e_de));
        check_v("sel_active",  32'(sel_active),  32'(e_sel));
        check_v("switching",   32'(switching),   32'(e_sw));
        check_v("sel_invalid", 32'(sel_invalid), 32'(e_inv));
    endtask

    task automatic drive();
        for (int k = 0; k < NS; k++) begin
            pos[k] = (pos[k] + 1) % fl[k];
            vs_in[k] = hold[k] || (pos[k] >= 5);
            hs_in[k] = (pos[k] % 16) >= 2;
            de_in[k] = ((pos[k] % 16) >= 4) && (pos[k] >= 20);
            r_in[k*CW +: CW] = CW'($urandom);
            g_in[k*CW +: CW] = CW'($urandom);
            b_in[k*CW +: CW] = CW'($urandom);
        end
    endtask

    task automatic model_reset();
        m_mode = M_BLANK; m_cur = 0; m_tgt = 0; m_left = BF; m_prev_req = 0;
        for (int k = 0; k < NS; k++) vs_last[k] = 1'b1;
        e_r = '0; e_g = '0; e_b = '0; e_de = 1'b0;
        e_hs = 1'b1; e_vs = 1'b1; e_sel = '0; e_sw = 1'b1; e_inv = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs just sampled.
    task automatic model_edge();
        int req;
        bit ok, fell;
        edge_n++;
        req  = int'(sel_req);
        ok   = req < NS;
        fell = vs_last[m_cur] && !vs_in[m_cur];
        e_hs = hs_in[m_cur];
        e_vs = vs_in[m_cur];
        if (m_mode == M_RUN) begin
            e_r = r_in[m_cur*CW +: CW]; e_g = g_in[m_cur*CW +: CW];
            e_b = b_in[m_cur*CW +: CW]; e_de = de_in[m_cur];
        end else begin
            e_r = '0; e_g = '0; e_b = '0; e_de = 1'b0;
        end
        e_inv = (req != m_prev_req) && !ok;
        m_prev_req = req;
        if (m_mode == M_RUN) begin
            if (ok && req != m_cur) begin
                m_tgt = req; deadline = edge_n + TO; m_mode = M_WAIT;
            end
        end else if (m_mode == M_WAIT) begin
            if (ok) m_tgt = req;
            if (fell || edge_n == deadline) begin
                m_cur = m_tgt; m_left = BF; m_mode = M_BLANK;
            end
        end else begin
            if (ok && req != m_cur) begin
                m_tgt = req; deadline = edge_n + TO; m_mode = M_WAIT;
            end else if (fell) begin
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end
        end
        e_sel = SW'(m_cur);
        e_sw  = (m_mode != M_RUN);
        for (int k = 0; k < NS; k++) vs_last[k] = vs_in[k];
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic wait_mode(input string tag, input int want, input int budget);
        int i;
        bit reached;
        i = 0;
        while (m_mode != want && i < budget) begin
            step();
            i++;
        end
        reached = (m_mode == want);
        check_v(tag, 32'(reached), 32'd1);
    endtask

    initial begin
        int inv_pulses;
        int i;
        longint n0;
        rst = 1'b1;
        sel_req = '0;
        for (int k = 0; k < NS; k++) begin
            pos[k] = 30 + 7 * k;
            hold[k] = 1'b0;
        end
        drive();
        do_reset();

        // Mid-frame reset, then settle on source 0.
        run(5);
        do_reset();
        wait_mode("settle_src0", M_RUN, 400);
        run(20);

        // Normal switch to source 1.
        sel_req = 2'd1;
        run(2);
        wait_mode("switch_src1", M_RUN, 600);
        run(20);

        // Invalid request: single pulse, no switch.
        sel_req = 2'd3;
        inv_pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sel_invalid) inv_pulses++;
        end
        check_v("inv_pulses", 32'(inv_pulses), 32'd1);
        check_v("inv_no_switch", 32'(switching), 32'd0);
        sel_req = 2'd1;
        run(5);

        // Switch to 2, then retarget from BLANK of a switch to 1.
        sel_req = 2'd2;
        run(2);
        wait_mode("switch_src2", M_RUN, 600);
        sel_req = 2'd1;
        run(2);
        wait_mode("blank_src1", M_BLANK, 400);
        run(3);
        sel_req = 2'd2;
        run(2);
        check_v("retarget_hold_sel", 32'(sel_active), 32'd1);
        wait_mode("retarget_done", M_RUN, 800);

        // Toggle back to the active source during WAIT_VS.
        sel_req = 2'd0;
        run(3);
        sel_req = 2'd2;
        run(2);
        wait_mode("toggle_done", M_RUN, 600);
        check_v("toggle_sel", 32'(sel_active), 32'd2);

        // Return to source 0 for the timeout case.
        sel_req = 2'd0;
        run(2);
        wait_mode("back_src0", M_RUN, 600);
        run(10);

        // Timeout: source 0 VSYNC stuck high.
        hold[0] = 1'b1;
        sel_req = 2'd1;
        n0 = edge_n;
        i = 0;
        do begin
            step();
            i++;
        end while (sel_active != 2'd1 && i < 1200);
        check_v("timeout_latency", 32'(edge_n - n0 - 1), 32'(TO));
        hold[0] = 1'b0;
        wait_mode("timeout_blank_done", M_RUN, 600);

        // Reset in the middle of a switch.
        sel_req = 2'd2;
        run(4);
        sel_req = 2'd0;
        do_reset();
        wait_mode("reset_mid_switch", M_RUN, 600);

        // Random requests, including invalid ones.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 49) == 0) sel_req = SW'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
